cardinal_nic_ctrl: RTL and testbench

PE-side controller that drives the memory-mapped port of one cardinal NIC (nicEn/nicWrEn/addr/d_in/d_out). It presents simple valid/ready transmit and receive streams to the processing element. A round-robin FSM schedules status polls, receive-buffer reads and transmit-buffer writes, so the PE never issues raw register accesses. Sits between the PE core and the NIC on every mesh node.

---
 rtl/nic_pkg.sv | 27 ++
 rtl/cardinal_nic_ctrl.sv | 154 +++++++++++++++
 tb/tb_cardinal_nic_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// ============================================================================
//  nic_pkg
//  Shared NIC register map, controller state encoding and packet width default.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package nic_pkg;

    localparam int PAC_WIDTH_DFLT = 64;

    localparam logic [1:0] RX_DATA = 2'b00;
    localparam logic [1:0] RX_STAT = 2'b01;
    localparam logic [1:0] TX_DATA = 2'b10;
    localparam logic [1:0] TX_STAT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RX_STAT  = 3'd1,
        S_RX_READ  = 3'd2,
        S_TX_STAT  = 3'd3,
        S_TX_WRITE = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cardinal_nic_ctrl.sv
// ============================================================================
//  cardinal_nic_ctrl
//  PE-side controller: turns valid/ready TX/RX streams into round-robin NIC
//  status polls, receive-buffer reads and transmit-buffer writes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cardinal_nic_ctrl
    import nic_pkg::*;
#(
    parameter int PAC_WIDTH = PAC_WIDTH_DFLT,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [0:1]           nic_addr,
    output logic                 nic_en,
    output logic                 nic_wr_en,
    output logic [0:PAC_WIDTH-1] nic_d_in,
    input  logic [0:PAC_WIDTH-1] nic_d_out,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [0:PAC_WIDTH-1] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [0:PAC_WIDTH-1] rx_data,
    output logic [0:CNT_WIDTH-1] tx_cnt,
    output logic [0:CNT_WIDTH-1] rx_cnt
);

    state_e                 r_state;
    logic [0:PAC_WIDTH-1]   r_tx_reg;
    logic                   r_tx_pend;
    logic [0:PAC_WIDTH-1]   r_rx_reg;
    logic                   r_rx_full;
    logic                   r_rr_last;
    logic [0:CNT_WIDTH-1]   r_tx_cnt;
    logic [0:CNT_WIDTH-1]   r_rx_cnt;
    logic                   r_nic_en;
    logic                   r_nic_wr_en;
    logic [0:1]             r_nic_addr;
    logic [0:PAC_WIDTH-1]   r_nic_d_in;

    logic w_status;
    logic w_rx_elig;
    logic w_tx_elig;
    logic w_tx_accept;
    logic w_rx_consume;
    logic w_pick_rx;

    // Only the last bit of a status word carries meaning.
    assign w_status     = nic_d_out[PAC_WIDTH-1];
    assign w_rx_elig    = !r_rx_full;
    assign w_tx_elig    = r_tx_pend;
    assign w_tx_accept  = tx_valid && !r_tx_pend;
    assign w_rx_consume = r_rx_full && rx_ready;
    // RX wins when alone, or on a tie when TX was served last.
    assign w_pick_rx    = w_rx_elig && (!w_tx_elig || r_rr_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tx_reg    <= '0;
            r_tx_pend   <= 1'b0;
            r_rx_reg    <= '0;
            r_rx_full   <= 1'b0;
            r_rr_last   <= 1'b1;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_nic_en    <= 1'b0;
            r_nic_wr_en <= 1'b0;
            r_nic_addr  <= RX_DATA;
            r_nic_d_in  <= '0;
        end else begin
            if (w_tx_accept) begin
                r_tx_reg  <= tx_data;
                r_tx_pend <= 1'b1;
            end
            if (w_rx_consume) begin
                r_rx_full <= 1'b0;
            end

            // Outputs are registered with the next state; idle values by default.
            r_nic_en    <= 1'b0;
            r_nic_wr_en <= 1'b0;
            r_nic_addr  <= RX_DATA;
            r_nic_d_in  <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_pick_rx) begin
                        r_state    <= S_RX_STAT;
                        r_rr_last  <= 1'b0;
                        r_nic_en   <= 1'b1;
                        r_nic_addr <= RX_STAT;
                    end else if (w_tx_elig) begin
                        r_state    <= S_TX_STAT;
                        r_rr_last  <= 1'b1;
                        r_nic_en   <= 1'b1;
                        r_nic_addr <= TX_STAT;
                    end
                end
                S_RX_STAT: begin
                    if (w_status) begin
                        r_state    <= S_RX_READ;
                        r_nic_en   <= 1'b1;
                        r_nic_addr <= RX_DATA;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RX_READ: begin
                    r_rx_reg  <= nic_d_out;
                    r_rx_full <= 1'b1;
                    r_rx_cnt  <= r_rx_cnt + CNT_WIDTH'(1);
                    r_state   <= S_IDLE;
                end
                S_TX_STAT: begin
                    if (!w_status) begin
                        r_state     <= S_TX_WRITE;
                        r_nic_en    <= 1'b1;
                        r_nic_wr_en <= 1'b1;
                        r_nic_addr  <= TX_DATA;
                        r_nic_d_in  <= r_tx_reg;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TX_WRITE: begin
                    r_tx_pend <= 1'b0;
                    r_tx_cnt  <= r_tx_cnt + CNT_WIDTH'(1);
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign nic_en    = r_nic_en;
    assign nic_wr_en = r_nic_wr_en;
    assign nic_addr  = r_nic_addr;
    assign nic_d_in  = r_nic_d_in;
    assign tx_ready  = !r_tx_pend;
    assign rx_valid  = r_rx_full;
    assign rx_data   = r_rx_reg;
    assign tx_cnt    = r_tx_cnt;
    assign rx_cnt    = r_rx_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cardinal_nic_ctrl.sv
// ============================================================================
//  tb_cardinal_nic_ctrl
//  Scoreboard bench: NIC behavioural model plus expected TX/RX packet queues.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cardinal_nic_ctrl;

    localparam int PW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:1]    nic_addr;
    logic          nic_en;
    logic          nic_wr_en;
    logic [0:PW-1] nic_d_in;
    logic [0:PW-1] nic_d_out;
    logic          tx_valid;
    logic          tx_ready;
    logic [0:PW-1] tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [0:PW-1] rx_data;
    logic [0:CW-1] tx_cnt;
    logic [0:CW-1] rx_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cardinal_nic_ctrl #(.PAC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .nic_addr  (nic_addr),
        .nic_en    (nic_en),
        .nic_wr_en (nic_wr_en),
        .nic_d_in  (nic_d_in),
        .nic_d_out (nic_d_out),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_cnt    (tx_cnt),
        .rx_cnt    (rx_cnt)
    );

    // NIC model state and scoreboards
    logic [0:PW-1] nic_q[$];
    logic [0:PW-1] rx_exp[$];
    logic [0:PW-1] tx_exp[$];
    int   stat_log[$];
    int   busy_polls;
    bit   busy_forever;
    bit   rand_mode;
    bit   m_rand_busy;
    logic m_rx_avail;
    logic m_tx_busy;
    logic [0:PW-1] m_rx_head;
    logic [0:PW-1] junk;
    int   n_acc, n_wr, n_rd, n_cons, n_rxstat, n_txstat;
    int   cyc;
    int   last_acc_cyc, last_wr_cyc, last_cons_cyc, last_rxstat_cyc;
    bit   pend_pop, pend_busy_dec;
    int   prev_kind;
    logic prev_status;
    bit   mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh_model();
        m_rx_avail = (nic_q.size() > 0);
        m_rx_head  = m_rx_avail ? nic_q[0] : '0;
        m_tx_busy  = busy_forever || (busy_polls > 0) || m_rand_busy;
    endtask

    task automatic clear_model();
        nic_q.delete(); rx_exp.delete(); tx_exp.delete(); stat_log.delete();
        n_acc = 0; n_wr = 0; n_rd = 0; n_cons = 0; n_rxstat = 0; n_txstat = 0;
        busy_polls = 0; busy_forever = 0; m_rand_busy = 0;
        pend_pop = 0; pend_busy_dec = 0; prev_kind = -1; prev_status = 1'b0;
        junk = '0;
        refresh_model();
    endtask

    task automatic push_rx(input logic [0:PW-1] p);
        nic_q.push_back(p);
        rx_exp.push_back(p);
        refresh_model();
    endtask

    // NIC register read data; non-status bits carry junk
    always_comb begin
        nic_d_out = junk;
        if (nic_en && !nic_wr_en) begin
            if (nic_addr == 2'b00)      nic_d_out = m_rx_head;
            else if (nic_addr == 2'b01) nic_d_out[PW-1] = m_rx_avail;
            else if (nic_addr == 2'b11) nic_d_out[PW-1] = m_tx_busy;
        end
    end

    // Monitor: applies last access's effect, then checks the current cycle
    always @(negedge clk) begin : mon
        int kind;
        logic st;
        logic [0:PW-1] pkt;
        if (mon_en && !reset) begin
            cyc++;
            if (pend_pop && nic_q.size() > 0) void'(nic_q.pop_front());
            if (pend_busy_dec && busy_polls > 0) busy_polls--;
            pend_pop = 0;
            pend_busy_dec = 0;
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                pkt = {$urandom, $urandom};
                nic_q.push_back(pkt);
                rx_exp.push_back(pkt);
            end
            m_rand_busy = rand_mode && ($urandom_range(0, 2) == 0);
            junk = {$urandom, $urandom};
            refresh_model();

            chk("tx_ready", 64'(tx_ready), 64'(n_acc == n_wr));
            chk("rx_valid", 64'(rx_valid), 64'(n_rd > n_cons));
            chk("tx_cnt", 64'(tx_cnt), 64'(n_wr % (1 << CW)));
            chk("rx_cnt", 64'(rx_cnt), 64'(n_rd % (1 << CW)));
            if (!nic_en) chk("wr_en_idle", 64'(nic_wr_en), 64'd0);
            if (!(nic_en && nic_wr_en)) chk("d_in_idle", nic_d_in, 64'd0);

            kind = -1;
            st   = 1'b0;
            if (nic_en) begin
                case (nic_addr)
                    2'b01: begin
                        chk("rx_stat_rd", 64'(nic_wr_en), 64'd0);
                        chk("rx_poll_while_full", 64'(rx_valid), 64'd0);
                        stat_log.push_back(1);
                        n_rxstat++;
                        last_rxstat_cyc = cyc;
                        kind = 1;
                        st   = m_rx_avail;
                    end
                    2'b00: begin
                        chk("rx_read_rd", 64'(nic_wr_en), 64'd0);
                        chk("rx_read_order", 64'({prev_kind == 1, prev_status}), 64'd3);
                        pend_pop = 1;
                        n_rd++;
                        kind = 0;
                    end
                    2'b11: begin
                        chk("tx_stat_rd", 64'(nic_wr_en), 64'd0);
                        chk("tx_stat_pending", 64'(tx_ready), 64'd0);
                        stat_log.push_back(2);
                        n_txstat++;
                        pend_busy_dec = 1;
                        kind = 3;
                        st   = m_tx_busy;
                    end
                    default: begin
                        chk("tx_write_wr", 64'(nic_wr_en), 64'd1);
                        chk("tx_write_order", 64'({prev_kind == 3, prev_status}), 64'd2);
                        if (tx_exp.size() == 0) chk("tx_write_unexpected", nic_d_in, 64'hx);
                        else chk("tx_write_data", nic_d_in, tx_exp.pop_front());
                        n_wr++;
                        last_wr_cyc = cyc;
                        kind = 2;
                    end
                endcase
            end
            prev_kind   = kind;
            prev_status = st;

            if (rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) chk("rx_unexpected", rx_data, 64'hx);
                else chk("rx_data", rx_data, rx_exp.pop_front());
                n_cons++;
                last_cons_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                tx_exp.push_back(tx_data);
                n_acc++;
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic send_tx(input logic [0:PW-1] d);
        int g = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        while (!tx_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("tx_accept_wait", 64'(tx_ready), 64'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string name);
        int g = 0;
        while (n_wr < target && g < 1000) begin
            @(posedge clk);
            g++;
        end
        chk(name, 64'(n_wr), 64'(target));
        #1;
    endtask

    task automatic wait_rxstat(input int target, input string name);
        int g = 0;
        while (n_rxstat < target && g < 1000) begin
            @(posedge clk);
            g++;
        end
        chk(name, 64'(n_rxstat), 64'(target));
        #1;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((n_acc != n_wr || nic_q.size() != 0 || n_rd != n_cons) && g < 5000) begin
            @(posedge clk);
            g++;
        end
        chk(name, 64'(n_acc != n_wr || nic_q.size() != 0 || n_rd != n_cons), 64'd0);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, w0, s0;
        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        mon_en = 0; rand_mode = 0; cyc = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nic_en", 64'(nic_en), 64'd0);
        chk("rst_wr_en", 64'(nic_wr_en), 64'd0);
        chk("rst_addr", 64'(nic_addr), 64'd0);
        chk("rst_d_in", nic_d_in, 64'd0);
        chk("rst_tx_ready", 64'(tx_ready), 64'd1);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_rx_data", rx_data, 64'd0);
        chk("rst_cnts", 64'({tx_cnt, rx_cnt}), 64'd0);

        // Both requesters eligible: RX first, then strict alternation
        busy_forever = 1;
        refresh_model();
        reset = 1'b0; mon_en = 1;
        tx_valid = 1'b1; tx_data = {$urandom, $urandom};
        @(posedge clk);
        #1 tx_valid = 1'b0;
        g = 0;
        while (stat_log.size() < 8 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("rr_log_len", 64'(stat_log.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < stat_log.size(); i++)
            chk("rr_order", 64'(stat_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        busy_forever = 0;
        refresh_model();
        wait_wr(1, "first_write");

        // Asynchronous reset during a NIC write
        send_tx({$urandom, $urandom});
        g = 0;
        @(negedge clk);
        while (!(nic_en && nic_wr_en) && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rst_write_seen", 64'(nic_en && nic_wr_en), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_nic_en", 64'(nic_en), 64'd0);
        chk("arst_tx_ready", 64'(tx_ready), 64'd1);
        chk("arst_tx_cnt", 64'(tx_cnt), 64'd0);
        @(posedge clk);
        #1 clear_model(); reset = 1'b0;
        @(negedge clk);
        #1 chk("post_rst_idle", 64'(nic_en), 64'd0);
        @(posedge clk);
        #1;

        // Received packet held while PE is not ready
        push_rx(64'h0123_4567_89AB_CDEF);
        g = 0;
        while (!rx_valid && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1 chk("rx_hold_data", rx_data, 64'h0123_4567_89AB_CDEF);
        repeat (10) @(posedge clk);
        #1 chk("rx_still_valid", 64'(rx_valid), 64'd1);

        // Single TX with RX blocked: write exactly 3 cycles after accept
        send_tx(64'h8000_0000_0000_00AA);
        wait_wr(1, "single_write");
        chk("tx_latency", 64'(last_wr_cyc - last_acc_cyc), 64'd3);
        chk("tx_cnt_single", 64'(tx_cnt), 64'd1);

        // TX status busy for 5 polls
        busy_polls = 5;
        refresh_model();
        s0 = n_txstat;
        w0 = n_wr;
        send_tx({$urandom, $urandom});
        wait_wr(w0 + 1, "busy_write");
        chk("busy_poll_count", 64'(n_txstat - s0), 64'd6);
        repeat (10) @(posedge clk);
        #1 chk("busy_single_write", 64'(n_wr - w0), 64'd1);

        // Consume; polling resumes once rx is empty
        s0 = n_rxstat;
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        wait_rxstat(s0 + 1, "rx_repoll");
        chk("rx_repoll_gap", 64'(last_rxstat_cyc - last_cons_cyc), 64'd2);
        chk("rx_data_kept", rx_data, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            tx_valid = ($urandom_range(0, 1) == 1);
            tx_data  = {$urandom, $urandom};
            rx_ready = ($urandom_range(0, 3) != 0);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        rand_mode = 0;
        m_rand_busy = 0;
        refresh_model();
        drain("drain_random");

        // Enough RX packets to wrap the counter
        for (int i = 0; i < 300; i++) push_rx({$urandom, $urandom});
        drain("drain_wrap");
        @(negedge clk);
        #1;
        chk("rx_cnt_wrap", 64'(rx_cnt), 64'(n_rd % (1 << CW)));
        chk("end_tx_ready", 64'(tx_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
